mwc_write_cntl: RTL

Parametrised manager write controller. It accepts write packets from the manager NoC, assembles the lane words into full DRAM lines spanning all channels, and queues them in a small request FIFO. It issues the lines to the main memory controller (MMC) with a valid/ready handshake, per-lane write mask and auto-incrementing address. It sits between the manager NoC controller and the MMC, beside the read controller.

---
 rtl/mwc_write_cntl_pkg.sv | 28 ++
 rtl/mwc_write_cntl_if.sv | 39 +++
 rtl/mwc_write_cntl_line_fifo.sv | 68 ++++++
 rtl/mwc_write_cntl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mwc_write_cntl_pkg.sv
// rtl/mwc_write_cntl_pkg.sv - framing encodings, packet type, FSM states and header field helpers
package mwc_write_cntl_pkg;

  // NoC framing: bit 0 marks start of message, bit 1 marks end of message
  localparam logic [1:0] MWC_CNTL_MOM     = 2'b00;
  localparam logic [1:0] MWC_CNTL_SOM     = 2'b01;
  localparam logic [1:0] MWC_CNTL_EOM     = 2'b10;
  localparam logic [1:0] MWC_CNTL_SOM_EOM = 2'b11;

  // packet type carried on the SOM beat that identifies a write
  localparam int MWC_TYPE_WRITE = 1;

  typedef enum logic [1:0] {
    MWC_ST_IDLE = 2'd0,
    MWC_ST_DATA = 2'd1,
    MWC_ST_DROP = 2'd2
  } mwc_state_e;

  // header layout: word at bit 0, bank directly above it, page above bank
  function automatic int mwc_hdr_bank_lsb(input int word_w);
    return word_w;
  endfunction

  function automatic int mwc_hdr_page_lsb(input int word_w, input int bank_w);
    return word_w + bank_w;
  endfunction

endpackage

// File: rtl/mwc_write_cntl_if.sv
// rtl/mwc_write_cntl_if.sv - NoC beat input and MMC line request bundle
interface mwc_write_cntl_if #(
  parameter int LANES      = 8,
  parameter int LANE_WIDTH = 32,
  parameter int BANK_W     = 3,
  parameter int PAGE_W     = 12,
  parameter int WORD_W     = 7,
  parameter int TYPE_W     = 3
);
  logic                        noc__mwc__dp_valid;
  logic [1:0]                  noc__mwc__dp_cntl;
  logic [TYPE_W-1:0]           noc__mwc__dp_type;
  logic [LANE_WIDTH-1:0]       noc__mwc__dp_data;
  logic                        mwc__noc__dp_ready;
  logic                        mwc__mmc__valid;
  logic                        mmc__mwc__ready;
  logic [BANK_W-1:0]           mwc__mmc__bank;
  logic [PAGE_W-1:0]           mwc__mmc__page;
  logic [WORD_W-1:0]           mwc__mmc__word;
  logic [LANES-1:0]            mwc__mmc__mask;
  logic [LANES*LANE_WIDTH-1:0] mwc__mmc__data;
  logic                        mwc__sys__err;

  // the write controller itself
  modport slave (
    input  noc__mwc__dp_valid, noc__mwc__dp_cntl, noc__mwc__dp_type, noc__mwc__dp_data,
    input  mmc__mwc__ready,
    output mwc__noc__dp_ready, mwc__mmc__valid, mwc__mmc__bank, mwc__mmc__page,
    output mwc__mmc__word, mwc__mmc__mask, mwc__mmc__data, mwc__sys__err
  );

  // the NoC source and MMC sink driving the controller
  modport master (
    output noc__mwc__dp_valid, noc__mwc__dp_cntl, noc__mwc__dp_type, noc__mwc__dp_data,
    output mmc__mwc__ready,
    input  mwc__noc__dp_ready, mwc__mmc__valid, mwc__mmc__bank, mwc__mmc__page,
    input  mwc__mmc__word, mwc__mmc__mask, mwc__mmc__data, mwc__sys__err
  );
endinterface

// File: rtl/mwc_write_cntl_line_fifo.sv
// rtl/mwc_write_cntl_line_fifo.sv - synchronous FIFO holding assembled line requests
module mwc_write_cntl_line_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // head entry comes straight from storage so it is stable while not popped
  assign rd_data = mem_q[rd_ptr_q];

  // next storage, pointers and occupancy from this cycle's push/pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // storage is cleared on reset so the head reads zero until the first push
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mwc_write_cntl.sv
// rtl/mwc_write_cntl.sv - assembles NoC write packets into DRAM line requests for the MMC
module mwc_write_cntl
  import mwc_write_cntl_pkg::*;
#(
  parameter int NUM_CHANNELS   = 2,
  parameter int WORDS_PER_LINE = 4,
  parameter int LANE_WIDTH     = 32,
  parameter int BANK_W         = 3,
  parameter int PAGE_W         = 12,
  parameter int WORD_W         = 7,
  parameter int TYPE_W         = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic            clk,
  input  logic            reset_poweron_n,
  mwc_write_cntl_if.slave bus
);
  localparam int LANES    = NUM_CHANNELS * WORDS_PER_LINE;
  localparam int IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DATA_W   = LANES * LANE_WIDTH;
  localparam int ENTRY_W  = BANK_W + PAGE_W + WORD_W + LANES + DATA_W;
  localparam int BANK_LSB = mwc_hdr_bank_lsb(WORD_W);
  localparam int PAGE_LSB = mwc_hdr_page_lsb(WORD_W, BANK_W);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LANES - 1);
  localparam logic [WORD_W-1:0] ALIGN_MASK = ~WORD_W'(WORDS_PER_LINE - 1);

  mwc_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]  lanes_q, lanes_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [PAGE_W-1:0]  page_q, page_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               err_q, err_d;

  logic               dp_ready, beat, beat_som, beat_eom, is_write;
  logic               fifo_full, fifo_empty, push;
  logic [LANES-1:0]   line_mask;
  logic [DATA_W-1:0]  line_data;
  logic [WORD_W-1:0]  word_next;
  logic               word_carry;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  // all beats stall while the FIFO is full, even ones that would not push
  assign dp_ready = reset_poweron_n && !fifo_full;
  assign beat     = bus.noc__mwc__dp_valid && dp_ready;
  assign beat_som = (bus.noc__mwc__dp_cntl == MWC_CNTL_SOM) || (bus.noc__mwc__dp_cntl == MWC_CNTL_SOM_EOM);
  assign beat_eom = (bus.noc__mwc__dp_cntl == MWC_CNTL_EOM) || (bus.noc__mwc__dp_cntl == MWC_CNTL_SOM_EOM);
  assign is_write = (bus.noc__mwc__dp_type == TYPE_W'(MWC_TYPE_WRITE));

  // the pushed line uses the current address; the advance only lands in the _d copy
  assign push_entry = {bank_q, page_q, word_q, line_mask, line_data};

  assign bus.mwc__noc__dp_ready = dp_ready;
  assign bus.mwc__mmc__valid    = !fifo_empty;
  assign bus.mwc__sys__err      = err_q;
  assign {bus.mwc__mmc__bank, bus.mwc__mmc__page, bus.mwc__mmc__word,
          bus.mwc__mmc__mask, bus.mwc__mmc__data} = head_entry;

  // packet framing, lane assembly, line push and address advance
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    lanes_d = lanes_q;
    bank_d  = bank_q;
    page_d  = page_q;
    word_d  = word_q;
    err_d   = 1'b0;
    push    = 1'b0;

    // current line with the incoming word merged at the write index
    line_mask = mask_q | (LANES'(1) << idx_q);
    line_data = lanes_q;
    line_data[idx_q*LANE_WIDTH +: LANE_WIDTH] = bus.noc__mwc__dp_data;
    {word_carry, word_next} = {1'b0, word_q} + (WORD_W+1)'(WORDS_PER_LINE);

    if (beat) begin
      if (state_q == MWC_ST_DROP) begin
        if (beat_eom) begin
          state_d = MWC_ST_IDLE;
        end
      end else if (beat_som) begin
        // a new header always restarts assembly; inside a packet it is a framing error
        err_d   = (state_q == MWC_ST_DATA);
        idx_d   = '0;
        mask_d  = '0;
        lanes_d = '0;
        if (beat_eom) begin
          state_d = MWC_ST_IDLE;
        end else if (is_write) begin
          state_d = MWC_ST_DATA;
          bank_d  = bus.noc__mwc__dp_data[BANK_LSB +: BANK_W];
          page_d  = bus.noc__mwc__dp_data[PAGE_LSB +: PAGE_W];
          word_d  = bus.noc__mwc__dp_data[WORD_W-1:0] & ALIGN_MASK;
        end else begin
          state_d = MWC_ST_DROP;
        end
      end else if (state_q == MWC_ST_IDLE) begin
        err_d = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        mask_d  = line_mask;
        lanes_d = line_data;
        // an EOM on the last lane falls in both cases but is a single push
        push    = (idx_q == LAST_IDX) || beat_eom;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          mask_d  = '0;
          lanes_d = '0;
          word_d  = word_next;
          if (word_carry) begin
            page_d = page_q + 1'b1;
          end
        end
        if (beat_eom) begin
          state_d = MWC_ST_IDLE;
          idx_d   = '0;
          mask_d  = '0;
          lanes_d = '0;
        end
      end
    end
  end

  // FSM state, assembly registers and the registered err pulse
  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      state_q <= MWC_ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      lanes_q <= '0;
      bank_q  <= '0;
      page_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      lanes_q <= lanes_d;
      bank_q  <= bank_d;
      page_q  <= page_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  mwc_write_cntl_line_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_line_fifo (
    .clk       (clk),
    .resetn    (reset_poweron_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (bus.mmc__mwc__ready),
    .rd_data   (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
